// File: rtl/tvip_reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the width rule for the requester-index output.
package tvip_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } seq_state_e;

  // Index width for n sources, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tvip_reset_cycle_counter.sv
// Clearable up-counter with a compare-done flag, used for both the hold time
// and the inter-domain stagger time.
module tvip_reset_cycle_counter #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [COUNT_WIDTH-1:0] limit_i,
  output logic                   done_o
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Caller guarantees limit_i >= 1; done marks the last counted cycle.
  assign done_o = en_i && (count_q >= (limit_i - COUNT_WIDTH'(1)));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tvip_reset_sequencer.sv
// Reset sequencer: holds all domains in reset, then releases them in ascending
// order with a programmable stagger; any request restarts the sequence.
module tvip_reset_sequencer
  import tvip_reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_REQUESTERS-1:0]              i_reset_request,
  input  logic [COUNT_WIDTH-1:0]                 i_assert_cycles,
  input  logic [COUNT_WIDTH-1:0]                 i_stagger_cycles,
  output logic [NUM_DOMAINS-1:0]                 o_reset_n,
  output logic                                   o_ready,
  output logic [NUM_REQUESTERS-1:0]              o_request_ack,
  output logic [idx_width(NUM_REQUESTERS)-1:0]   o_last_source
);

  localparam int unsigned SrcW = idx_width(NUM_REQUESTERS);

  seq_state_e                state_q, state_d;
  logic [NUM_DOMAINS-1:0]    rst_q, rst_d;
  logic                      ready_q, ready_d;
  logic [NUM_REQUESTERS-1:0] ack_q, ack_d;
  logic [SrcW-1:0]           last_q, last_d;

  logic                   req_any, stagger_zero;
  logic [SrcW-1:0]        req_low;
  logic [COUNT_WIDTH-1:0] hold_limit, stg_limit;
  logic                   hold_en, hold_clr, hold_done;
  logic                   stg_en, stg_clr, stg_done;

  assign req_any      = |i_reset_request;
  assign stagger_zero = (i_stagger_cycles == '0);
  assign hold_limit   = (i_assert_cycles == '0) ? COUNT_WIDTH'(1) : i_assert_cycles;
  assign stg_limit    = stagger_zero ? COUNT_WIDTH'(1) : i_stagger_cycles;

  // A request seen in ASSERT restarts the full hold time.
  assign hold_en  = (state_q == StAssert) && !req_any;
  assign hold_clr = (state_q != StAssert) || req_any || hold_done;
  assign stg_en   = (state_q == StRelease);
  assign stg_clr  = (state_q != StRelease) || stg_done;

  always_comb begin
    req_low = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      if (i_reset_request[i]) req_low = SrcW'(i);
    end
  end

  tvip_reset_cycle_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_hold_cnt (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (hold_clr),
    .en_i    (hold_en),
    .limit_i (hold_limit),
    .done_o  (hold_done)
  );

  tvip_reset_cycle_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_stagger_cnt (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (stg_clr),
    .en_i    (stg_en),
    .limit_i (stg_limit),
    .done_o  (stg_done)
  );

  // rst_q is a thermometer code: released domains shift in from bit 0.
  always_comb begin
    state_d = state_q;
    rst_d   = rst_q;
    ack_d   = '0;
    last_d  = last_q;
    unique case (state_q)
      StAssert: begin
        rst_d = '0;
        if (hold_done) begin
          rst_d   = stagger_zero ? '1 : NUM_DOMAINS'(1);
          state_d = (&rst_d) ? StRun : StRelease;
        end
      end
      StRelease: begin
        if (req_any) begin
          state_d = StAssert;
          rst_d   = '0;
          ack_d   = i_reset_request;
          last_d  = req_low;
        end else if (stg_done || stagger_zero) begin
          rst_d = stagger_zero ? '1 : ((rst_q << 1) | NUM_DOMAINS'(1));
          if (&rst_d) state_d = StRun;
        end
      end
      StRun: begin
        if (req_any) begin
          state_d = StAssert;
          rst_d   = '0;
          ack_d   = i_reset_request;
          last_d  = req_low;
        end
      end
      default: begin
        state_d = StAssert;
        rst_d   = '0;
      end
    endcase
    ready_d = (state_d == StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StAssert;
      rst_q   <= '0;
      ready_q <= 1'b0;
      ack_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
    end
  end

  assign o_reset_n     = rst_q;
  assign o_ready       = ready_q;
  assign o_request_ack = ack_q;
  assign o_last_source = last_q;

endmodule

// File: tb/tb_tvip_reset_sequencer.sv
// Directed bench for the reset sequencer with 4 requesters, 3 domains,
// hold 4 cycles and stagger 2 cycles unless a test overrides them.
module tb_tvip_reset_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] assert_cycles;
  logic [15:0] stagger_cycles;
  logic [2:0]  rstn_o;
  logic        ready_o;
  logic [3:0]  ack_o;
  logic [1:0]  last_o;

  int total = 0;
  int bad   = 0;

  // Expected o_reset_n on edges 0..8 of a sequence with hold 4, stagger 2.
  logic [2:0] rstn_exp [0:8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                                 3'b001, 3'b011, 3'b011, 3'b111};

  tvip_reset_sequencer #(
    .NUM_REQUESTERS (4),
    .NUM_DOMAINS    (3),
    .COUNT_WIDTH    (16)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_reset_request  (req),
    .i_assert_cycles  (assert_cycles),
    .i_stagger_cycles (stagger_cycles),
    .o_reset_n        (rstn_o),
    .o_ready          (ready_o),
    .o_request_ack    (ack_o),
    .o_last_source    (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is just past edge 0 of a sequence; walk edges 1..n.
  task automatic check_seq(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s rstn e%0d", tag, k), {29'd0, rstn_o}, {29'd0, rstn_exp[k]});
      check($sformatf("%s ready e%0d", tag, k), {31'd0, ready_o}, {31'd0, (k == 8)});
      check($sformatf("%s ack e%0d", tag, k), {28'd0, ack_o}, 32'd0);
    end
  endtask

  task automatic check_entry(input string tag, input logic [3:0] ack_e, input logic [1:0] last_e);
    check({tag, " rstn"}, {29'd0, rstn_o}, 32'd0);
    check({tag, " ready"}, {31'd0, ready_o}, 32'd0);
    check({tag, " ack"}, {28'd0, ack_o}, {28'd0, ack_e});
    check({tag, " last"}, {30'd0, last_o}, {30'd0, last_e});
  endtask

  initial begin
    rst_n          = 1'b0;
    req            = 4'b0000;
    assert_cycles  = 16'd4;
    stagger_cycles = 16'd2;

    tick();
    check_entry("reset", 4'b0000, 2'd0);

    // Power-on sequence, no request.
    tick();
    rst_n = 1'b1;
    check_seq("por", 8);

    // Single-cycle request from requester 2 in RUN.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check_entry("req2", 4'b0100, 2'd2);
    check_seq("req2 seq", 8);

    // Request 0 held ten cycles: hold restarts from the last high sample.
    req = 4'b0001;
    tick();
    check_entry("hold0", 4'b0001, 2'd0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("hold0 rstn h%0d", k), {29'd0, rstn_o}, 32'd0);
      check($sformatf("hold0 ack h%0d", k), {28'd0, ack_o}, 32'd0);
    end
    req = 4'b0000;
    check_seq("hold0 seq", 8);

    // Abort during RELEASE right after domain 0 opens.
    req = 4'b0010;
    tick();
    req = 4'b0000;
    check_entry("pre-abort", 4'b0010, 2'd1);
    check_seq("pre-abort seq", 4);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    check_entry("abort3", 4'b1000, 2'd3);
    check_seq("abort3 seq", 8);

    // Two simultaneous requests, zero hold and zero stagger.
    assert_cycles  = 16'd0;
    stagger_cycles = 16'd0;
    req            = 4'b1010;
    tick();
    req = 4'b0000;
    check_entry("dual", 4'b1010, 2'd1);
    tick();
    check("dual fast rstn", {29'd0, rstn_o}, 32'h7);
    check("dual fast ready", {31'd0, ready_o}, 32'd1);

    // Asynchronous reset in the middle of RELEASE.
    assert_cycles  = 16'd4;
    stagger_cycles = 16'd2;
    req            = 4'b1000;
    tick();
    req = 4'b0000;
    check_entry("pre-async", 4'b1000, 2'd3);
    check_seq("pre-async seq", 5);
    #3;
    rst_n = 1'b0;
    #1;
    check_entry("async", 4'b0000, 2'd0);
    tick();
    rst_n = 1'b1;
    check_seq("after async", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
